// File: rtl/rs_preio_link_pkg.sv
// rtl/rs_preio_link_pkg.sv - shared types and helpers for the pre-I/O serial link
package rs_preio_link_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int frame_bits(input int data_w, input int parity_en);
        return data_w + 2 + parity_en;
    endfunction

endpackage

// File: rtl/rs_preio_link_rx.sv
// rtl/rs_preio_link_rx.sv - receive half: line synchronizer, deframer and error flags
module rs_preio_link_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err
);
    import rs_preio_link_pkg::*;

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF     = TW'(CLKS_PER_BIT / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    logic              sync1;
    logic              sync2;
    logic              prev;
    rx_state_t         state;
    logic [TW-1:0]     timer;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              bit_end;

    assign bit_end = (timer == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= LINE_IDLE;
            sync2   <= LINE_IDLE;
            prev    <= LINE_IDLE;
            state   <= RX_IDLE;
            timer   <= '0;
            idx     <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            data    <= '0;
            valid   <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            prev  <= sync2;
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    timer <= '0;
                    if (prev && !sync2) state <= RX_START;
                end
                // Mid-start resample rejects short low glitches.
                RX_START: begin
                    if (timer == HALF) begin
                        timer <= '0;
                        idx   <= '0;
                        state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        shift <= {sync2, shift[DATA_W-1:1]};
                        if (idx == IDX_LAST) state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        else                 idx   <= idx + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (bit_end) begin
                        timer   <= '0;
                        par_bit <= sync2;
                        state   <= RX_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        timer   <= '0;
                        data    <= shift;
                        valid   <= 1'b1;
                        par_err <= (PARITY_EN != 0) && ((^shift) != par_bit);
                        frm_err <= !sync2;
                        state   <= RX_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rs_preio_link.sv
// rtl/rs_preio_link.sv - fabric-side bit-serial link: inline TX framer plus RX deframer
module rs_preio_link #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              FPGA_CLK,
    input  logic              FPGA_RST,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              FPGA_OUT,
    input  logic              FPGA_IN,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              RX_PAR_ERR,
    output logic              RX_FRM_ERR
);
    import rs_preio_link_pkg::*;

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("rs_preio_link: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    tx_state_t         tx_state;
    logic [TW-1:0]     tx_timer;
    logic [IW-1:0]     tx_idx;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_shift_next;
    logic              tx_par;
    logic              tx_line;
    logic              tx_bit_end;
    logic              tx_load;

    assign tx_bit_end    = (tx_timer == BIT_LAST);
    assign tx_shift_next = tx_shift >> 1;
    // Ready in the last stop cycle lets the next frame start with no idle gap.
    assign TX_READY = !FPGA_RST &&
                      ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));
    assign tx_load  = TX_VALID && TX_READY;
    assign FPGA_OUT = tx_line | FPGA_RST;

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= LINE_IDLE;
        end else if (tx_load) begin
            tx_shift <= TX_DATA;
            tx_par   <= ^TX_DATA;
            tx_line  <= 1'b0;
            tx_timer <= '0;
            tx_state <= TX_START;
        end else if (tx_state == TX_IDLE) begin
            tx_timer <= '0;
        end else if (!tx_bit_end) begin
            tx_timer <= tx_timer + 1'b1;
        end else begin
            tx_timer <= '0;
            case (tx_state)
                TX_START: begin
                    tx_idx   <= '0;
                    tx_line  <= tx_shift[0];
                    tx_state <= rs_preio_link_pkg::TX_DATA;
                end
                rs_preio_link_pkg::TX_DATA: begin
                    if (tx_idx == IDX_LAST) begin
                        tx_line  <= (PARITY_EN != 0) ? tx_par : LINE_IDLE;
                        tx_state <= (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_idx   <= tx_idx + 1'b1;
                        tx_shift <= tx_shift_next;
                        tx_line  <= tx_shift_next[0];
                    end
                end
                TX_PARITY: begin
                    tx_line  <= LINE_IDLE;
                    tx_state <= TX_STOP;
                end
                default: begin
                    tx_line  <= LINE_IDLE;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    rs_preio_link_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_EN    (PARITY_EN)
    ) u_rx (
        .clk     (FPGA_CLK),
        .rst     (FPGA_RST),
        .line    (FPGA_IN),
        .data    (RX_DATA),
        .valid   (RX_VALID),
        .par_err (RX_PAR_ERR),
        .frm_err (RX_FRM_ERR)
    );

endmodule
